// File: rtl/imem_boot_ctrl_pkg.sv
// imem_boot_ctrl_pkg: shared FSM states and constants for the boot loader (CHK only with IMEM_BOOT_CHECKSUM_EN)
package imem_boot_ctrl_pkg;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEF_ADDR_W = 3;
    localparam int LANE_W = $clog2(BYTES_PER_WORD);
`ifdef IMEM_BOOT_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_CHK, S_RUN, S_ERR} state_t;
    localparam state_t S_POST_LOAD = S_CHK;
`else
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOAD, S_RUN, S_ERR} state_t;
    localparam state_t S_POST_LOAD = S_RUN;
`endif
endpackage

// File: rtl/imem_boot_ctrl_if.sv
// imem_boot_ctrl_if: byte stream, memory write port and core control of the boot loader
interface imem_boot_ctrl_if import imem_boot_ctrl_pkg::*; #(parameter int ADDR_W = DEF_ADDR_W);
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;
    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, err
    );
    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, mem_we, mem_waddr, mem_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/imem_boot_ctrl_packer.sv
// imem_word_packer: assembles little-endian bytes into 32-bit words and flags the completing byte
module imem_word_packer import imem_boot_ctrl_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_done
);
    logic [LANE_W-1:0] r_lane;
    logic [31:0]       r_word;
    // o_word already includes the byte being accepted, so the completed word is ready same cycle
    always_comb begin
        o_word = r_word;
        o_word[{r_lane, 3'b000} +: 8] = i_byte;
        o_word_done = i_byte_en && (r_lane == LANE_W'(BYTES_PER_WORD - 1));
    end
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (i_byte_en) begin
            r_word <= o_word;
            r_lane <= r_lane + 1'b1;
        end
    end
endmodule

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: loads a header-counted byte stream into instruction memory, then releases the core
// Optional IMEM_BOOT_CHECKSUM_EN adds a trailing XOR checksum byte checked in state CHK.
module imem_boot_ctrl import imem_boot_ctrl_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic clk,
    input logic rst,
    imem_boot_ctrl_if.slave bus
);
    localparam logic [8:0]      DEPTH9 = 9'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] ONE = 1;
    state_t            r_state, w_next;
    logic [ADDR_W:0]   r_n, r_wcnt;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              w_xfer, w_start_ok, w_load_en, w_word_done, w_last, w_bad_hdr;
    logic [31:0]       w_word;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif
    assign w_xfer     = bus.rx_valid && bus.rx_ready;
    assign w_start_ok = bus.start && (r_state == S_IDLE || r_state == S_RUN || r_state == S_ERR);
    assign w_load_en  = w_xfer && r_state == S_LOAD;
    assign w_last     = (r_wcnt + ONE) == r_n;
    assign w_bad_hdr  = (bus.rx_data == 8'd0) || ({1'b0, bus.rx_data} > DEPTH9);
    imem_word_packer u_packer (
        .clk(clk),
        .rst(rst),
        .i_clr(w_start_ok),
        .i_byte_en(w_load_en),
        .i_byte(bus.rx_data),
        .o_word(w_word),
        .o_word_done(w_word_done)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_RUN, S_ERR: w_next = bus.start ? S_HDR : r_state;
            S_HDR:  w_next = w_xfer ? (w_bad_hdr ? S_ERR : S_LOAD) : S_HDR;
            S_LOAD: w_next = (w_word_done && w_last) ? S_POST_LOAD : S_LOAD;
`ifdef IMEM_BOOT_CHECKSUM_EN
            S_CHK:  w_next = w_xfer ? ((bus.rx_data == r_csum) ? S_RUN : S_ERR) : S_CHK;
`endif
            default: w_next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_wcnt   <= '0;
            r_mem_we <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_state  <= w_next;
            r_mem_we <= w_word_done;
            if (r_state == S_HDR && w_xfer)
                r_n <= bus.rx_data[ADDR_W:0];
            if (w_start_ok)
                r_wcnt <= '0;
            else if (w_word_done) begin
                r_waddr <= r_wcnt[ADDR_W-1:0];
                r_wdata <= w_word;
                r_wcnt  <= r_wcnt + ONE;
            end
        end
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || w_start_ok)
            r_csum <= '0;
        else if (w_load_en)
            r_csum <= r_csum ^ bus.rx_data;
    end
    assign bus.rx_ready = r_state == S_HDR || r_state == S_LOAD || r_state == S_CHK;
`else
    assign bus.rx_ready = r_state == S_HDR || r_state == S_LOAD;
`endif
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_waddr = r_waddr;
    assign bus.mem_wdata = r_wdata;
    assign bus.cpu_hold  = r_state != S_RUN;
    assign bus.done      = r_state == S_RUN;
    assign bus.err       = r_state == S_ERR;
endmodule

// File: tb/tb_imem_boot_ctrl.sv
// tb_imem_boot_ctrl: directed boot-stream vectors with a write scoreboard checked by a negedge monitor
module tb_imem_boot_ctrl;
    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
    } wr_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] tb_xor;
    wr_t exp_q[$];
    imem_boot_ctrl_if #(.ADDR_W(3)) bus();
    imem_boot_ctrl #(.ADDR_W(3)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_we: got write addr %0d data %h expected none", bus.mem_waddr, bus.mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("we_addr", 32'(bus.mem_waddr), 32'(e.addr));
                chk("we_data", bus.mem_wdata, e.data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data = b;
        while (bus.rx_ready !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        if (t == 20) begin
            n_chk++;
            n_fail++;
            $display("FAIL rx_ready_timeout: got rx_ready=0 expected 1 within 20 cycles");
        end
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_pay(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        send_byte(b);
        tb_xor ^= b;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tb_xor = 8'h00;
    endtask

    task automatic end_load();
`ifdef IMEM_BOOT_CHECKSUM_EN
        send_byte(tb_xor);
`endif
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e, input logic h);
        chk({tag, "_done"}, 32'(bus.done), 32'(d));
        chk({tag, "_err"}, 32'(bus.err), 32'(e));
        chk({tag, "_hold"}, 32'(bus.cpu_hold), 32'(h));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk_status(tag, 1'b0, 1'b0, 1'b1);
        chk({tag, "_ready"}, 32'(bus.rx_ready), 32'd0);
        chk({tag, "_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_waddr"}, 32'(bus.mem_waddr), 32'd0);
        chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        tb_xor = 8'h00;
        repeat (2) tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();
        // nominal two-word load
        do_start();
        chk("hdr_ready", 32'(bus.rx_ready), 32'd1);
        push(3'd0, 32'h0000_0013);
        push(3'd1, 32'h0010_0093);
        send_byte(8'h02);
        send_pay(8'h13, 0); send_pay(8'h00, 0); send_pay(8'h00, 0); send_pay(8'h00, 0);
        send_pay(8'h93, 0); send_pay(8'h00, 0); send_pay(8'h10, 0); send_pay(8'h00, 0);
        end_load();
        tick();
        chk_status("nominal", 1'b1, 1'b0, 1'b0);
        chk("nominal_ready", 32'(bus.rx_ready), 32'd0);
        // start from RUN raises cpu_hold on the next cycle
        bus.start = 1'b1;
        chk("run_hold_before", 32'(bus.cpu_hold), 32'd0);
        tick();
        bus.start = 1'b0;
        chk("run_hold_after", 32'(bus.cpu_hold), 32'd1);
        send_byte(8'h00);
        chk_status("hdr00", 1'b0, 1'b1, 1'b1);
        chk("hdr00_ready", 32'(bus.rx_ready), 32'd0);
        do_start();
        chk("restart_err", 32'(bus.err), 32'd0);
        chk("restart_ready", 32'(bus.rx_ready), 32'd1);
        send_byte(8'h09);
        chk_status("hdr09", 1'b0, 1'b1, 1'b1);
        // one word with gaps on rx_valid
        do_start();
        push(3'd0, 32'h1234_5678);
        send_byte(8'h01);
        send_pay(8'h78, 2); send_pay(8'h56, 1); send_pay(8'h34, 3); send_pay(8'h12, 1);
        repeat (2) tick();
        end_load();
        tick();
        chk_status("gaps", 1'b1, 1'b0, 1'b0);
        // reset lands on the cycle of word 1's final byte
        do_start();
        push(3'd0, 32'h4433_2211);
        send_byte(8'h02);
        send_pay(8'h11, 0); send_pay(8'h22, 0); send_pay(8'h33, 0); send_pay(8'h44, 0);
        send_pay(8'h55, 0); send_pay(8'h66, 0); send_pay(8'h77, 0);
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h88;
        rst = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        chk_reset_vals("midrst");
        rst = 1'b0;
        repeat (3) tick();
        chk_reset_vals("midrst_idle");
        // full-depth load
        do_start();
        send_byte(8'h08);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'(i);
            push(3'(i), {8'hF0 | b, b + 8'h20, b + 8'h10, b});
            send_pay(b, 0); send_pay(b + 8'h10, 0); send_pay(b + 8'h20, 0); send_pay(8'hF0 | b, 0);
        end
        end_load();
        tick();
        chk_status("full", 1'b1, 1'b0, 1'b0);
`ifdef IMEM_BOOT_CHECKSUM_EN
        do_start();
        push(3'd0, 32'h0000_0013);
        send_byte(8'h01);
        send_pay(8'h13, 0); send_pay(8'h00, 0); send_pay(8'h00, 0); send_pay(8'h00, 0);
        send_byte(8'h13);
        tick();
        chk_status("csum_ok", 1'b1, 1'b0, 1'b0);
        do_start();
        push(3'd0, 32'h0000_0013);
        send_byte(8'h01);
        send_pay(8'h13, 0); send_pay(8'h00, 0); send_pay(8'h00, 0); send_pay(8'h00, 0);
        send_byte(8'h12);
        tick();
        chk_status("csum_bad", 1'b0, 1'b1, 1'b1);
`endif
        repeat (4) tick();
        chk("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
